// File: rtl/mul_pkg.sv
// Shared definitions for the sequential 32x32->32 multiplier: state encoding,
// the byte-pair step table and fixed datapath widths.
package mul_pkg;

  localparam int unsigned MUL_STEPS = 10;
  localparam int unsigned W         = 32;
  localparam int unsigned BW        = 8;
  localparam int unsigned PW        = 16;
  localparam int unsigned KW        = 4;
  localparam int unsigned SW        = 3;

  localparam logic [SW-1:0] ST_IDLE = 3'b001;
  localparam logic [SW-1:0] ST_CALC = 3'b010;
  localparam logic [SW-1:0] ST_DONE = 3'b100;

  // i/j select operand bytes; sh = i+j is the byte weight of the partial product
  typedef struct packed {
    logic [1:0] i;
    logic [1:0] j;
    logic [1:0] sh;
  } step_t;

  // Only pairs with i+j <= 3 contribute to the low 32 bits
  function automatic step_t step_of(input logic [KW-1:0] k);
    step_t s;
    case (k)
      4'd0:    s = {2'd0, 2'd0, 2'd0};
      4'd1:    s = {2'd0, 2'd1, 2'd1};
      4'd2:    s = {2'd1, 2'd0, 2'd1};
      4'd3:    s = {2'd0, 2'd2, 2'd2};
      4'd4:    s = {2'd1, 2'd1, 2'd2};
      4'd5:    s = {2'd2, 2'd0, 2'd2};
      4'd6:    s = {2'd0, 2'd3, 2'd3};
      4'd7:    s = {2'd1, 2'd2, 2'd3};
      4'd8:    s = {2'd2, 2'd1, 2'd3};
      4'd9:    s = {2'd3, 2'd0, 2'd3};
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/byte_mul_8x8.sv
// Combinational unsigned 8x8->16 multiplier shared across all steps.
module byte_mul_8x8
  import mul_pkg::*;
(
  input  logic [BW-1:0] x,
  input  logic [BW-1:0] y,
  output logic [PW-1:0] p
);

  assign p = {8'd0, x} * {8'd0, y};

endmodule

// File: rtl/mul_seq.sv
// Sequential multiplier: low 32 bits of a*b via one time-shared byte multiplier,
// ten accumulate steps per operation, valid/ready on both sides, flush abort.
module mul_seq
  import mul_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         busy
);

  logic [SW-1:0] state, state_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [W-1:0]  acc, acc_nxt;
  logic [W-1:0]  a_reg, a_nxt;
  logic [W-1:0]  b_reg, b_nxt;
  logic [BW-1:0] a_byte, b_byte;
  logic [PW-1:0] prod;
  logic [W-1:0]  term;
  step_t         st;

  assign st     = step_of(k);
  assign a_byte = a_reg[{st.i, 3'b000} +: BW];
  assign b_byte = b_reg[{st.j, 3'b000} +: BW];
  assign term   = {16'd0, prod} << {st.sh, 3'b000};

  byte_mul_8x8 u_byte_mul (
    .x (a_byte),
    .y (b_byte),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    acc_nxt   = acc;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt = ST_CALC;
          a_nxt     = a;
          b_nxt     = b;
          acc_nxt   = '0;
          k_nxt     = '0;
        end
      end
      ST_CALC: begin
        acc_nxt = acc + term;
        if (k == KW'(MUL_STEPS - 1)) begin
          state_nxt = ST_DONE;
          k_nxt     = '0;
        end else begin
          k_nxt = KW'(k + KW'(1));
        end
      end
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort beats any handshake; the pending result is dropped via state
    if (flush) begin
      state_nxt = ST_IDLE;
      k_nxt     = '0;
      a_nxt     = a_reg;
      b_nxt     = b_reg;
    end
  end

  // Datapath and registered outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      acc       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out       <= '0;
    end else begin
      k         <= k_nxt;
      acc       <= acc_nxt;
      a_reg     <= a_nxt;
      b_reg     <= b_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
      busy      <= (state_nxt != ST_IDLE);
      out       <= (state_nxt == ST_DONE) ? acc_nxt : '0;
    end
  end

endmodule
